// File: rtl/dual_port_memory_monitor.sv
// Passive scoreboard for a 1W/1R memory: shadows every write and checks read data
// returned READ_LATENCY cycles after each read address.
module dual_port_memory_monitor #(
    parameter int unsigned DATA_WIDTH    = 6,
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned READ_LATENCY  = 1,
    parameter bit          STOP_ON_ERROR = 1'b0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iCheckEnable,
    input  logic                  iWriteEnable,
    input  logic [ADDR_WIDTH-1:0] iWriteAddress,
    input  logic [DATA_WIDTH-1:0] iDataIn,
    input  logic [ADDR_WIDTH-1:0] iReadAddress0,
    input  logic [DATA_WIDTH-1:0] iDataOut0,
    output logic [DATA_WIDTH-1:0] oExpected,
    output logic                  oCheckValid,
    output logic                  oMismatch,
    output logic [15:0]           oCheckCount,
    output logic [15:0]           oErrorCount,
    output logic [1:0]            oState
);

    localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [DATA_WIDTH-1:0] r_shadow [DEPTH];
    logic [DEPTH-1:0]      r_written;
    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic                  w_lookup_valid;
    logic [DATA_WIDTH-1:0] w_lookup_data;
    logic                  w_check_valid;
    logic [DATA_WIDTH-1:0] w_expected;
    logic                  w_mismatch;
    logic [CNT_W-1:0]      r_check_count;
    logic [CNT_W-1:0]      r_error_count;

    // Shadow data is never reset; the written bits alone decide eligibility.
    always_ff @(posedge Clock) begin
        if (iWriteEnable) begin
            r_shadow[iWriteAddress] <= iDataIn;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_written <= '0;
        end else if (iWriteEnable) begin
            r_written[iWriteAddress] <= 1'b1;
        end
    end

    // Lookup sees the array before this cycle's write lands (read-first).
    always_comb begin
        w_lookup_valid = 1'b0;
        w_lookup_data  = '0;
        if (r_state == ST_RUN) begin
            w_lookup_valid = r_written[iReadAddress0];
            w_lookup_data  = r_shadow[iReadAddress0];
        end
    end

    generate
        if (READ_LATENCY == 0) begin : g_comb
            assign w_check_valid = w_lookup_valid;
            assign w_expected    = w_lookup_data;
        end else begin : g_pipe
            logic                  r_pipe_vld  [READ_LATENCY];
            logic [DATA_WIDTH-1:0] r_pipe_data [READ_LATENCY];

            for (genvar g = 0; g < int'(READ_LATENCY); g++) begin : g_stage
                if (g == 0) begin : g_first
                    always_ff @(posedge Clock or negedge Reset) begin
                        if (!Reset) begin
                            r_pipe_vld[g]  <= 1'b0;
                            r_pipe_data[g] <= '0;
                        end else begin
                            r_pipe_vld[g]  <= w_lookup_valid;
                            r_pipe_data[g] <= w_lookup_data;
                        end
                    end
                end else begin : g_next
                    always_ff @(posedge Clock or negedge Reset) begin
                        if (!Reset) begin
                            r_pipe_vld[g]  <= 1'b0;
                            r_pipe_data[g] <= '0;
                        end else begin
                            r_pipe_vld[g]  <= r_pipe_vld[g-1];
                            r_pipe_data[g] <= r_pipe_data[g-1];
                        end
                    end
                end
            end

            assign w_check_valid = r_pipe_vld[READ_LATENCY-1];
            assign w_expected    = r_pipe_data[READ_LATENCY-1];
        end
    endgenerate

    assign w_mismatch = w_check_valid && (iDataOut0 != w_expected);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Leaving RUN only stops new lookups; in-flight entries still drain.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (iCheckEnable) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!iCheckEnable) begin
                    w_state_next = ST_IDLE;
                end else if (STOP_ON_ERROR && w_mismatch) begin
                    w_state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (!iCheckEnable) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Saturating counters.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_check_count <= '0;
            r_error_count <= '0;
        end else begin
            if (w_check_valid && (r_check_count != CNT_MAX)) begin
                r_check_count <= r_check_count + CNT_W'(1);
            end
            if (w_mismatch && (r_error_count != CNT_MAX)) begin
                r_error_count <= r_error_count + CNT_W'(1);
            end
        end
    end

    assign oExpected   = w_expected;
    assign oCheckValid = w_check_valid;
    assign oMismatch   = w_mismatch;
    assign oCheckCount = r_check_count;
    assign oErrorCount = r_error_count;
    assign oState      = r_state;

endmodule

// File: tb/tb_dual_port_memory_monitor.sv
// Directed bench: one free-running monitor and one STOP_ON_ERROR monitor share the
// same stimulus; expected values are hand-computed per cycle.
module tb_dual_port_memory_monitor;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       we;
    logic [7:0] wa;
    logic [5:0] di;
    logic [7:0] ra;
    logic [5:0] dout;

    logic [5:0]  exp_a, exp_h;
    logic        vld_a, vld_h;
    logic        mm_a,  mm_h;
    logic [15:0] cc_a,  cc_h;
    logic [15:0] ec_a,  ec_h;
    logic [1:0]  st_a,  st_h;

    int n_checks = 0;
    int n_errors = 0;

    dual_port_memory_monitor #(
        .DATA_WIDTH(6), .ADDR_WIDTH(8), .READ_LATENCY(1), .STOP_ON_ERROR(1'b0)
    ) dut (
        .Clock(clk), .Reset(rst_n), .iCheckEnable(en), .iWriteEnable(we),
        .iWriteAddress(wa), .iDataIn(di), .iReadAddress0(ra), .iDataOut0(dout),
        .oExpected(exp_a), .oCheckValid(vld_a), .oMismatch(mm_a),
        .oCheckCount(cc_a), .oErrorCount(ec_a), .oState(st_a)
    );

    dual_port_memory_monitor #(
        .DATA_WIDTH(6), .ADDR_WIDTH(8), .READ_LATENCY(1), .STOP_ON_ERROR(1'b1)
    ) dut_h (
        .Clock(clk), .Reset(rst_n), .iCheckEnable(en), .iWriteEnable(we),
        .iWriteAddress(wa), .iDataIn(di), .iReadAddress0(ra), .iDataOut0(dout),
        .oExpected(exp_h), .oCheckValid(vld_h), .oMismatch(mm_h),
        .oCheckCount(cc_h), .oErrorCount(ec_h), .oState(st_h)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // One clock: inputs change just after the rising edge, outputs are sampled at the falling edge.
    task automatic step(input logic w, input logic [7:0] waddr, input logic [5:0] wdata,
                        input logic [7:0] raddr, input logic [5:0] rdata);
        @(posedge clk);
        #1;
        we   = w;
        wa   = waddr;
        di   = wdata;
        ra   = raddr;
        dout = rdata;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        we    = 1'b0;
        wa    = '0;
        di    = '0;
        ra    = '0;
        dout  = '0;

        repeat (2) @(negedge clk);
        check("rst_state", 32'(st_a), 0);
        check("rst_valid", 32'(vld_a), 0);
        check("rst_mismatch", 32'(mm_a), 0);
        check("rst_expected", 32'(exp_a), 0);
        check("rst_ccount", 32'(cc_a), 0);
        check("rst_ecount", 32'(ec_a), 0);

        rst_n = 1'b1;
        en    = 1'b1;

        // Never-written address 5 is not compared.
        step(1'b0, 8'd0, 6'd0, 8'd5, 6'd0);
        check("unwr_state_run", 32'(st_a), 1);
        step(1'b0, 8'd0, 6'd0, 8'd5, 6'd0);
        check("unwr_valid", 32'(vld_a), 0);
        step(1'b0, 8'd0, 6'd0, 8'd5, 6'd0);
        check("unwr_valid2", 32'(vld_a), 0);
        check("unwr_ccount", 32'(cc_a), 0);
        check("unwr_ecount", 32'(ec_a), 0);

        // Write 15..8 to 7..0, then read 7..0 back with correct data.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(7 - i), 6'(15 - i), 8'd0, 6'd0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'd0, 6'd0, 8'(7 - i), (i == 0) ? 6'd0 : 6'(16 - i));
            if (i == 0) begin
                check("seq_valid_first", 32'(vld_a), 0);
            end else begin
                check("seq_valid", 32'(vld_a), 1);
                check("seq_expected", 32'(exp_a), 32'(16 - i));
                check("seq_mismatch", 32'(mm_a), 0);
            end
        end
        step(1'b0, 8'd0, 6'd0, 8'd200, 6'd8);
        check("seq_valid_last", 32'(vld_a), 1);
        check("seq_expected_last", 32'(exp_a), 8);
        check("seq_mismatch_last", 32'(mm_a), 0);
        step(1'b0, 8'd0, 6'd0, 8'd200, 6'd0);
        check("seq_valid_idle", 32'(vld_a), 0);
        check("seq_ccount", 32'(cc_a), 8);
        check("seq_ecount", 32'(ec_a), 0);

        // Wrong data returned for address 3.
        step(1'b1, 8'd3, 6'h0A, 8'd200, 6'd0);
        step(1'b0, 8'd0, 6'd0, 8'd3, 6'd0);
        step(1'b0, 8'd0, 6'd0, 8'd200, 6'h0B);
        check("bad_valid", 32'(vld_a), 1);
        check("bad_expected", 32'(exp_a), 32'h0A);
        check("bad_mismatch", 32'(mm_a), 1);
        check("bad_mismatch_h", 32'(mm_h), 1);
        step(1'b0, 8'd0, 6'd0, 8'd200, 6'd0);
        check("bad_pulse_end", 32'(mm_a), 0);
        check("bad_ecount", 32'(ec_a), 1);
        check("bad_ccount", 32'(cc_a), 9);
        check("halt_state", 32'(st_h), 2);

        // Same-address write and read: old value first, new value on the next read.
        step(1'b1, 8'd2, 6'd4, 8'd200, 6'd0);
        step(1'b1, 8'd2, 6'd9, 8'd2, 6'd0);
        step(1'b0, 8'd0, 6'd0, 8'd2, 6'd4);
        check("coll_valid", 32'(vld_a), 1);
        check("coll_expected_old", 32'(exp_a), 4);
        check("coll_mismatch", 32'(mm_a), 0);
        step(1'b0, 8'd0, 6'd0, 8'd200, 6'd9);
        check("coll_expected_new", 32'(exp_a), 9);
        check("coll_valid2", 32'(vld_a), 1);
        step(1'b0, 8'd0, 6'd0, 8'd200, 6'd0);
        check("coll_ccount", 32'(cc_a), 11);
        check("coll_ecount", 32'(ec_a), 1);

        // Halted monitor ignores further bad reads until disabled.
        check("halt_ecount", 32'(ec_h), 1);
        check("halt_ccount", 32'(cc_h), 9);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'd0, 6'd0, 8'd3, 6'h3F);
            check("halt_no_mismatch", 32'(mm_h), 0);
            check("halt_no_valid", 32'(vld_h), 0);
        end
        step(1'b0, 8'd0, 6'd0, 8'd200, 6'd0);
        check("halt_ecount_frozen", 32'(ec_h), 1);
        check("halt_state_held", 32'(st_h), 2);
        en = 1'b0;
        step(1'b0, 8'd0, 6'd0, 8'd200, 6'd0);
        check("halt_to_idle", 32'(st_h), 0);
        check("run_to_idle", 32'(st_a), 0);

        // Reset with a failing compare in flight.
        en = 1'b1;
        step(1'b0, 8'd0, 6'd0, 8'd200, 6'd0);
        step(1'b0, 8'd0, 6'd0, 8'd2, 6'h3F);
        @(posedge clk);
        #2;
        check("inflight_valid", 32'(vld_a), 1);
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(st_a), 0);
        check("arst_valid", 32'(vld_a), 0);
        check("arst_expected", 32'(exp_a), 0);
        check("arst_mismatch", 32'(mm_a), 0);
        check("arst_ccount", 32'(cc_a), 0);
        check("arst_ecount", 32'(ec_a), 0);
        check("arst_ecount_h", 32'(ec_h), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'd0, 6'd0, 8'd2, 6'h3F);
            check("post_rst_mismatch", 32'(mm_a), 0);
            check("post_rst_valid", 32'(vld_a), 0);
        end
        check("post_rst_state", 32'(st_a), 1);
        check("post_rst_ccount", 32'(cc_a), 0);
        check("post_rst_ecount", 32'(ec_a), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dual_port_memory_monitor.md
DUAL_PORT_MEMORY_MONITOR -- requirements
Module: dual_port_memory_monitor

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 6, giving the data word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, giving the address width; the shadow depth is 2^ADDR_WIDTH.
REQ-003 The block SHALL have parameter READ_LATENCY, default 1, legal values 0 to 3, giving cycles from read address to valid memory output.
REQ-004 The block SHALL have parameter STOP_ON_ERROR, default 0; when 1, the first mismatch halts checking.
REQ-005 The block SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port iCheckEnable, input, 1 bit: arms and keeps the checker running.
REQ-008 The block SHALL have port iWriteEnable, input, 1 bit: the write strobe observed on the memory write port.
REQ-009 The block SHALL have port iWriteAddress, input, ADDR_WIDTH bits: the observed write address.
REQ-010 The block SHALL have port iDataIn, input, DATA_WIDTH bits: the observed write data.
REQ-011 The block SHALL have port iReadAddress0, input, ADDR_WIDTH bits: the observed read address, sampled every cycle.
REQ-012 The block SHALL have port iDataOut0, input, DATA_WIDTH bits: the memory read data under check.
REQ-013 The block SHALL have port oExpected, output, DATA_WIDTH bits: the expected read data aligned with iDataOut0.
REQ-014 The block SHALL have port oCheckValid, output, 1 bit: high when the current cycle is a compared read.
REQ-015 The block SHALL have port oMismatch, output, 1 bit: one-cycle pulse on a compare failure.
REQ-016 The block SHALL have port oCheckCount, output, 16 bits: the number of compared reads.
REQ-017 The block SHALL have port oErrorCount, output, 16 bits: the number of mismatches.
REQ-018 The block SHALL have port oState, output, 2 bits: IDLE=0, RUN=1, HALT=2.

Function
REQ-019 The block SHALL keep a shadow array of 2^ADDR_WIDTH words plus a per-entry written bit, updated on every write while iWriteEnable=1 in any state.
REQ-020 In each cycle with oState=RUN, the block SHALL look up iReadAddress0 and form expected data from the shadow value before that cycle's write (read-first on a same-address collision).
REQ-021 The block SHALL form an eligibility flag as written bit AND oState=RUN at lookup time.
REQ-022 The block SHALL delay expected data and eligibility through a READ_LATENCY-stage pipeline; with READ_LATENCY=0 the compare is combinational in the same cycle.
REQ-023 oCheckValid SHALL equal the delayed eligibility; oExpected SHALL equal the delayed expected data.
REQ-024 The block SHALL NOT compare reads of never-written addresses; oCheckValid stays 0 for them.
REQ-025 When oCheckValid=1 and iDataOut0!=oExpected, the block SHALL assert oMismatch for exactly that cycle and increment oErrorCount.
REQ-026 When oCheckValid=1, the block SHALL increment oCheckCount.
REQ-027 Both counters SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-028 State IDLE SHALL move to RUN on iCheckEnable=1.
REQ-029 State RUN SHALL move to IDLE on iCheckEnable=0; pipeline entries already in flight still complete their compares.
REQ-030 State RUN SHALL move to HALT on a mismatch when STOP_ON_ERROR=1.
REQ-031 State HALT SHALL issue no new lookups, keep counters frozen after draining the pipeline, and move to IDLE only on iCheckEnable=0.
REQ-032 Write and compare in the same cycle to different addresses SHALL both take effect.

Reset
REQ-033 While Reset=0, the block SHALL asynchronously force oState=IDLE, clear all written bits, and clear the pipeline.
REQ-034 While Reset=0, all outputs SHALL be 0, including oCheckCount and oErrorCount.
REQ-035 Shadow data contents need not be cleared.
REQ-036 On reset deassertion mid-operation, in-flight compares SHALL be discarded with no oMismatch pulse.

Verification
REQ-037 The bench SHALL write 15..8 to addresses 7..0, then read 7..0 with correct data at READ_LATENCY=1 -> oCheckCount=8, oErrorCount=0, no oMismatch.
REQ-038 The bench SHALL write addr 3=5'h0A, then return 6'h0B on a read of addr 3 -> one oMismatch pulse with oExpected=6'h0A, oErrorCount=1.
REQ-039 The bench SHALL read never-written addr 5 -> oCheckValid=0, counters unchanged.
REQ-040 The bench SHALL hold addr 2=4, then write 9 and read addr 2 in the same cycle -> oExpected=4; the next read gives oExpected=9.
REQ-041 With STOP_ON_ERROR=1, the bench SHALL force a mismatch, then issue more bad reads -> oState=HALT, oErrorCount stays 1; iCheckEnable=0 -> oState=IDLE.
REQ-042 The bench SHALL pulse Reset low with a compare in flight -> all outputs 0 immediately, no oMismatch after release, and a prior address reads as unwritten.
